// File: rtl/spi_ram_pkg.sv
// Shared command encoding for the SPI RAM endpoint.
package spi_ram_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port storage array with registered read data; contents are never reset.
module spi_ram_array #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_SIZE];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_burst_ram.sv
// Command decoder, burst pointers and sticky error flag in front of the RAM array.
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 2**ADDR_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W+CMD_W-1:0] din,
    input  logic                    rx_valid,
    output logic [DATA_W-1:0]       dout,
    output logic                    tx_valid,
    output logic                    err
);

    if (DATA_W < ADDR_SIZE) begin : g_bad_width
        $error("spi_burst_ram: DATA_W must be >= ADDR_SIZE");
    end
    if (MEM_DEPTH != 2**ADDR_SIZE) begin : g_bad_depth
        $error("spi_burst_ram: MEM_DEPTH must equal 2**ADDR_SIZE");
    end

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic                 wr_armed_q, wr_armed_d;
    logic                 rd_armed_q, rd_armed_d;
    logic                 err_q, err_d;
    logic                 tx_valid_q;
    logic [DATA_W-1:0]    dout_hold_q;
    logic                 wr_fire, rd_fire;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [DATA_W-1:0]    ram_rdata;

    assign cmd     = cmd_e'(din[DATA_W+CMD_W-1:DATA_W]);
    assign wr_fire = !rst && rx_valid && (cmd == CMD_WR_DATA) && wr_armed_q;
    assign rd_fire = !rst && rx_valid && (cmd == CMD_RD_DATA) && rd_armed_q;

    assign ram_addr = (cmd == CMD_RD_DATA) ? rd_ptr_q : wr_ptr_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_armed_d = wr_armed_q;
        rd_armed_d = rd_armed_q;
        err_d      = err_q;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_ptr_d   = din[ADDR_SIZE-1:0];
                    wr_armed_d = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (wr_armed_q) wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
                    else            err_d    = 1'b1;
                end
                CMD_RD_ADDR: begin
                    rd_ptr_d   = din[ADDR_SIZE-1:0];
                    rd_armed_d = 1'b1;
                end
                CMD_RD_DATA: begin
                    if (rd_armed_q) rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
                    else            err_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_armed_q  <= 1'b0;
            rd_armed_q  <= 1'b0;
            err_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            dout_hold_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_armed_q  <= wr_armed_d;
            rd_armed_q  <= rd_armed_d;
            err_q       <= err_d;
            tx_valid_q  <= rd_fire;
            dout_hold_q <= dout;
        end
    end

    spi_ram_array #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_W    (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (wr_fire),
        .addr  (ram_addr),
        .wdata (din[DATA_W-1:0]),
        .rdata (ram_rdata)
    );

    // The array reads every cycle, so dout shows fresh data only after a fired read
    // and otherwise the last value presented (zero after reset).
    assign dout     = tx_valid_q ? ram_rdata : dout_hold_q;
    assign tx_valid = tx_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Scoreboard bench for spi_burst_ram at 8/8 and 4/16 address/data widths.
module tb_spi_burst_ram;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  din8;
    logic        rx8;
    logic [7:0]  dout8;
    logic        tx8, err8;
    logic [17:0] din16;
    logic        rx16;
    logic [15:0] dout16;
    logic        tx16, err16;

    spi_burst_ram #(.ADDR_SIZE(8), .DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .rx_valid(rx8),
        .dout(dout8), .tx_valid(tx8), .err(err8)
    );

    spi_burst_ram #(.ADDR_SIZE(4), .DATA_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .din(din16), .rx_valid(rx16),
        .dout(dout16), .tx_valid(tx16), .err(err16)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model, index 0 = 8-bit DUT, index 1 = 16-bit DUT
    logic [15:0] m_mem [2][256];
    logic [7:0]  m_wp [2];
    logic [7:0]  m_rp [2];
    bit          m_wa [2];
    bit          m_ra [2];
    bit          m_err [2];
    logic [15:0] q8 [$];
    logic [15:0] q16 [$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_wp[d] = 8'd0; m_rp[d] = 8'd0;
            m_wa[d] = 1'b0; m_ra[d] = 1'b0; m_err[d] = 1'b0;
        end
    endtask

    task automatic op(input int d, input cmd_e c, input logic [15:0] p);
        logic [7:0]  amask;
        logic [15:0] dmask;
        amask = (d == 0) ? 8'hFF : 8'h0F;
        dmask = (d == 0) ? 16'h00FF : 16'hFFFF;
        @(negedge clk);
        if (d == 0) begin
            din8 = {c, p[7:0]}; rx8 = 1'b1; rx16 = 1'b0;
        end else begin
            din16 = {c, p}; rx16 = 1'b1; rx8 = 1'b0;
        end
        case (c)
            CMD_WR_ADDR: begin m_wp[d] = p[7:0] & amask; m_wa[d] = 1'b1; end
            CMD_WR_DATA: begin
                if (m_wa[d]) begin
                    m_mem[d][m_wp[d]] = p & dmask;
                    m_wp[d] = (m_wp[d] + 8'd1) & amask;
                end else m_err[d] = 1'b1;
            end
            CMD_RD_ADDR: begin m_rp[d] = p[7:0] & amask; m_ra[d] = 1'b1; end
            CMD_RD_DATA: begin
                if (m_ra[d]) begin
                    if (d == 0) q8.push_back(m_mem[d][m_rp[d]]);
                    else        q16.push_back(m_mem[d][m_rp[d]]);
                    m_rp[d] = (m_rp[d] + 8'd1) & amask;
                end else m_err[d] = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx8 = 1'b0; rx16 = 1'b0;
        end
    endtask

    // Reset pulse with an armed-looking read command on din to prove rst wins.
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; rx8 = 1'b1; din8 = {CMD_RD_DATA, 8'h00}; rx16 = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0; rx8 = 1'b0;
        check("rst_dout8", 32'(dout8), 32'h0);
        check("rst_tx8", 32'(tx8), 32'h0);
        check("rst_err8", 32'(err8), 32'h0);
    endtask

    always @(negedge clk) begin
        if (tx8) begin
            if (q8.size() == 0) check("tx8_unexpected", 32'(tx8), 32'h0);
            else                check("rd8", 32'(dout8), 32'(q8.pop_front()));
        end
        if (tx16) begin
            if (q16.size() == 0) check("tx16_unexpected", 32'(tx16), 32'h0);
            else                 check("rd16", 32'(dout16), 32'(q16.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx8 = 1'b0; rx16 = 1'b0; din8 = '0; din16 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("init_dout8", 32'(dout8), 32'h0);
        check("init_tx8", 32'(tx8), 32'h0);
        check("init_err8", 32'(err8), 32'h0);
        check("init_dout16", 32'(dout16), 32'h0);
        check("init_tx16", 32'(tx16), 32'h0);
        check("init_err16", 32'(err16), 32'h0);

        // Burst write then burst read
        op(0, CMD_WR_ADDR, 16'h10);
        op(0, CMD_WR_DATA, 16'hA1);
        op(0, CMD_WR_DATA, 16'hA2);
        op(0, CMD_WR_DATA, 16'hA3);
        op(0, CMD_RD_ADDR, 16'h10);
        op(0, CMD_RD_DATA, 16'h0);
        op(0, CMD_RD_DATA, 16'h0);
        op(0, CMD_RD_DATA, 16'h0);
        idle(2);
        check("burst_err8", 32'(err8), 32'h0);
        check("burst_drained", 32'(q8.size()), 32'h0);

        // Pointer wrap at top of memory
        op(0, CMD_WR_ADDR, 16'hFF);
        op(0, CMD_WR_DATA, 16'h11);
        op(0, CMD_WR_DATA, 16'h22);
        op(0, CMD_RD_ADDR, 16'hFF);
        op(0, CMD_RD_DATA, 16'h0);
        op(0, CMD_RD_DATA, 16'h0);

        // Read-after-write
        op(0, CMD_WR_ADDR, 16'h20);
        op(0, CMD_WR_DATA, 16'h5A);
        op(0, CMD_RD_ADDR, 16'h20);
        op(0, CMD_RD_DATA, 16'h0);
        idle(2);
        check("wrap_raw_drained", 32'(q8.size()), 32'h0);

        // Reset in the middle of a read burst
        op(0, CMD_RD_ADDR, 16'h10);
        op(0, CMD_RD_DATA, 16'h0);
        op(0, CMD_RD_DATA, 16'h0);
        pulse_reset();
        op(0, CMD_RD_DATA, 16'h0);
        idle(1);
        check("abort_tx8", 32'(tx8), 32'h0);
        check("abort_err8", 32'(err8), 32'(m_err[0]));
        op(0, CMD_RD_ADDR, 16'h10);
        op(0, CMD_RD_DATA, 16'h0);
        idle(2);

        // Unarmed read: no output, sticky error through valid traffic
        pulse_reset();
        op(0, CMD_RD_DATA, 16'h0);
        idle(2);
        check("unarmed_tx8", 32'(tx8), 32'h0);
        check("unarmed_dout8", 32'(dout8), 32'h0);
        check("unarmed_err8", 32'(err8), 32'h1);
        op(0, CMD_WR_ADDR, 16'h30);
        op(0, CMD_WR_DATA, 16'h77);
        op(0, CMD_RD_ADDR, 16'h30);
        op(0, CMD_RD_DATA, 16'h0);
        idle(2);
        check("sticky_err8", 32'(err8), 32'h1);

        // Unarmed write must not touch memory
        pulse_reset();
        op(0, CMD_WR_DATA, 16'hEE);
        op(0, CMD_RD_ADDR, 16'h00);
        op(0, CMD_RD_DATA, 16'h0);
        idle(2);
        check("unarmed_wr_err8", 32'(err8), 32'h1);
        check("mem0_kept", 32'(m_mem[0][0]), 32'h22);

        // 4-bit address / 16-bit data: wrap and ignored upper payload bits
        op(1, CMD_WR_ADDR, 16'hABCF);
        op(1, CMD_WR_DATA, 16'hBEEF);
        op(1, CMD_WR_DATA, 16'h1234);
        op(1, CMD_RD_ADDR, 16'h5A0F);
        op(1, CMD_RD_DATA, 16'h0);
        op(1, CMD_RD_DATA, 16'h0);
        idle(2);
        check("w16_err16", 32'(err16), 32'h0);
        check("w16_model0", 32'(m_mem[1][0]), 32'h1234);
        check("w16_modelF", 32'(m_mem[1][15]), 32'hBEEF);

        idle(2);
        check("final_q8", 32'(q8.size()), 32'h0);
        check("final_q16", 32'(q16.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_burst_ram.md
# spi_burst_ram

Parametrised single-port RAM endpoint behind the SPI slave. Accepts `{cmd, payload}` words from the slave's receive path and returns read data on its transmit path. Generalises the fixed 8-bit/256-deep RAM in three ways:
- configurable data width and depth;
- auto-incrementing burst access on both ports;
- a sticky protocol-error flag for commands issued out of order.

## Interface
Parameters:
- `ADDR_SIZE`, default 8: address width; `MEM_DEPTH = 2**ADDR_SIZE`.
- `DATA_W`, default 8: data word width. Elaboration error if `DATA_W < ADDR_SIZE`.
- `MEM_DEPTH`, default 256: derived, must equal `2**ADDR_SIZE`. Checked at elaboration.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `din`, input, `DATA_W+2`: command word. `din[DATA_W+1:DATA_W]` is the command, `din[DATA_W-1:0]` is the payload.
- `rx_valid`, input, 1: `din` valid this cycle. One command per cycle.
- `dout`, output, `DATA_W`: read data, registered.
- `tx_valid`, output, 1: one-cycle pulse marking `dout` valid.
- `err`, output, 1: sticky protocol error.

## Operation
Commands are decoded only when `rx_valid` = 1. With `rx_valid` = 0, all state holds.

- `CMD_WR_ADDR` (2'b00):
  - `wr_ptr <= din[ADDR_SIZE-1:0]`;
  - set `wr_armed`.
- `CMD_WR_DATA` (2'b01):
  - if `wr_armed`: `mem[wr_ptr] <= din[DATA_W-1:0]` and `wr_ptr <= wr_ptr + 1`;
  - otherwise: no write and set `err`.
- `CMD_RD_ADDR` (2'b10):
  - `rd_ptr <= din[ADDR_SIZE-1:0]`;
  - set `rd_armed`.
- `CMD_RD_DATA` (2'b11):
  - if `rd_armed`: `dout <= mem[rd_ptr]`, `tx_valid <= 1`, and `rd_ptr <= rd_ptr + 1`;
  - otherwise: `dout` holds, `tx_valid` stays 0, and set `err`.

Pointer arithmetic is modulo `MEM_DEPTH`. Incrementing `MEM_DEPTH-1` wraps to 0, with no flag raised.

Payload bits `[DATA_W-1:ADDR_SIZE]` are ignored on address commands.

Arming is per-pointer state, tracked by two bits:
- `wr_armed` and `rd_armed` are independent;
- once set, each stays set until reset;
- re-issuing an ADDR command reloads the pointer only.

`err` is set by either unarmed DATA command and is cleared only by `rst`.

Read data is taken from the array at the time the `CMD_RD_DATA` cycle is sampled. A `CMD_WR_DATA` in cycle N to address A is visible to a `CMD_RD_DATA` of A in cycle N+1 or later.

## Timing
- `rst` high at a clock edge sets:
  - `dout` = 0, `tx_valid` = 0, `err` = 0;
  - `wr_ptr` = `rd_ptr` = 0;
  - both armed bits cleared.
- `rst` has priority over `rx_valid`. Memory contents are not cleared.
- Reset asserted mid-burst aborts the burst. The next DATA command requires a fresh ADDR command.
- Read latency is 1:
  - `CMD_RD_DATA` sampled at edge N gives `dout` and `tx_valid` = 1 after edge N;
  - `tx_valid` falls after edge N+1 unless another armed `CMD_RD_DATA` is sampled at N+1.
- Back-to-back `CMD_RD_DATA` produces continuous `tx_valid` with sequential addresses. Throughput is one word per clock.
- Write takes effect at the sampling edge. There is no stall and no backpressure.
- `err` rises one edge after the offending command.

## Structure
- Package `spi_ram_pkg` holds:
  - `typedef enum logic [1:0] cmd_e` with values `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA`;
  - the width helper `CMD_W` = 2.
- Sub-module `spi_ram_array` is the storage:
  - parameters `ADDR_SIZE` and `DATA_W`;
  - one port: `we`, `addr`, `wdata`, registered `rdata`;
  - no reset on the array.
- The top level holds the decoder, pointers, armed bits, `err` and the `tx_valid` register. The single address mux selects `wr_ptr` or `rd_ptr` by command.

## Test plan
1. Reset, then `CMD_WR_ADDR` 0x10, then `CMD_WR_DATA` 0xA1, 0xA2, 0xA3, then `CMD_RD_ADDR` 0x10, then three `CMD_RD_DATA` -> `dout` = 0xA1, 0xA2, 0xA3 on three consecutive cycles with `tx_valid` high throughout; `err` = 0.
2. `CMD_WR_ADDR` 0xFF, then `CMD_WR_DATA` 0x11, 0x22 -> `mem[0xFF]` = 0x11, `mem[0x00]` = 0x22. A read burst from 0xFF returns 0x11, 0x22 (wrap-around).
3. After reset, `CMD_RD_DATA` with no `CMD_RD_ADDR` -> `tx_valid` stays 0, `dout` = 0, `err` = 1 and stays 1 through later valid traffic until `rst`.
4. `CMD_WR_DATA` 0x5A to 0x20, immediately followed by `CMD_RD_ADDR` 0x20 and `CMD_RD_DATA` -> `dout` = 0x5A (read-after-write).
5. Assert `rst` during a 4-word read burst after word 2 -> `tx_valid` = 0 and `dout` = 0 next cycle; a following `CMD_RD_DATA` sets `err`. Data written before the reset is still readable after a new `CMD_RD_ADDR`.
6. Parameter sweep with `ADDR_SIZE` = 4, `DATA_W` = 16: write 0xBEEF at 0xF and 0x1234 at 0x0 in one burst from 0xF -> readback matches. Payload bits [15:4] on address commands are ignored.
